alu_checker: RTL and testbench
==============================

ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 SHALL have parameters: WIDTH, 32, datapath width; ALU_LAT, 1, ALU result latency in cycles (legal 1..4).
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a check run.
- op_valid  input  1  operation issued to ALU this cycle.
- op_last  input  1  qualifies op_valid; marks final op of run.
- operand_a  input  WIDTH  operand A as issued to ALU.
- operand_b  input  WIDTH  operand B as issued to ALU.
- alu_ctrl  input  4  opcode as issued to ALU.
- alu_result  input  WIDTH  ALU output under check.
- zero_flag  input  1  ALU zero output under check.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at run end.
- pass_count  output  16  matched ops this run.
- fail_count  output  16  mismatched ops this run.
- err_flag  output  1  sticky; any mismatch this run.
- err_ctrl  output  4  opcode of first mismatch.
- err_expected  output  WIDTH  expected result of first mismatch.
- err_actual  output  WIDTH  alu_result of first mismatch.

Function
REQ-003 SHALL compute expected result per opcode: 0000 a+b; 0001 a-b; 0010 a&b; 0011 a|b; 0100 a^b; 0101 a<<b[4:0]; 0110 logical a>>b[4:0]; 0111 arithmetic a>>>b[4:0]; 1000 signed a<b ? 1 : 0; 1001 unsigned a<b ? 1 : 0; 1010-1111 zero. Add/sub wrap modulo 2^WIDTH.
REQ-004 SHALL delay expected value, opcode and valid through an ALU_LAT-deep pipeline so an op issued in cycle N compares against alu_result in cycle N+ALU_LAT.
REQ-005 SHALL use FSM states IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start; RUN -> DRAIN on op_valid&&op_last; DRAIN -> DONE after ALU_LAT cycles; DONE -> IDLE next cycle.
REQ-006 SHALL ignore op_valid in IDLE, DRAIN and DONE; only RUN-state ops enter the pipeline.
REQ-007 SHALL clear counters, err_flag and err_* on entering RUN from start; start in any non-IDLE state is ignored.
REQ-008 SHALL assert busy in RUN and DRAIN; done high only in DONE.
REQ-009 SHALL increment pass_count on match and fail_count on mismatch for each op exiting the pipeline; both saturate at 16'hFFFF.
REQ-010 SHALL capture err_ctrl, err_expected, err_actual on the first mismatch only; later mismatches update fail_count only.
REQ-011 SHALL compare ops still in flight during DRAIN; the op_last op is counted before done.
REQ-012 SHALL hold counters and err_* stable from DONE until the next start.

Reset
REQ-013 SHALL on rst_n low, asynchronously, force state IDLE, pipeline valids 0, busy 0, done 0, counters 0, err_flag 0, err_ctrl 0, err_expected 0, err_actual 0.
REQ-014 SHALL discard in-flight ops on reset mid-run; no done pulse follows.

Configuration
REQ-015 SHALL honour macro ALU_CHK_ZERO_CHECK_EN: defined -> mismatch when alu_result differs OR zero_flag != (expected==0); undefined -> zero_flag ignored, result compare only.

Verification
REQ-016 ALU_LAT=1: start; ADD a=10,b=20; ALU returns 30 -> pass_count=1, fail_count=0, err_flag=0.
REQ-017 SUB a=30,b=10 (op_last); ALU returns 21 -> fail_count=1, err_flag=1, err_ctrl=0001, err_expected=20, err_actual=21, done one cycle after DRAIN.
REQ-018 AND 0xF0F0&0x0FF0 then SLL 1<<5 (op_last), ALU returns 0x00F0, 0x20 -> pass_count=2, done pulses once, busy low afterward.
REQ-019 ALU_CHK_ZERO_CHECK_EN defined: SUB a=5,b=5, alu_result=0, zero_flag=0 -> fail_count=1; macro undefined -> pass_count=1.
REQ-020 Two mismatches (ADD, XOR) -> fail_count=2, err_ctrl=0000 retained; reset asserted mid-run -> all outputs 0, no done.

Source files
------------

// File: rtl/alu_checker.sv
// alu_checker: recomputes every ALU op issued during a run and compares it against the
// ALU output ALU_LAT cycles later. Define ALU_CHK_ZERO_CHECK_EN to also check zero_flag.
module alu_checker #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_valid,
    input  logic             op_last,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             zero_flag,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pass_count,
    output logic [15:0]      fail_count,
    output logic             err_flag,
    output logic [3:0]       err_ctrl,
    output logic [WIDTH-1:0] err_expected,
    output logic [WIDTH-1:0] err_actual
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(ALU_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic [1:0]       drain_cnt;
    logic [4:0]       shamt;
    logic             lt_signed;
    logic             lt_unsigned;
    logic [WIDTH-1:0] exp_now;
    logic             issue;
    logic             run_clear;

    logic             pipe_valid [ALU_LAT];
    logic [WIDTH-1:0] pipe_exp   [ALU_LAT];
    logic [3:0]       pipe_ctrl  [ALU_LAT];

    logic             chk_valid;
    logic [WIDTH-1:0] chk_exp;
    logic [3:0]       chk_ctrl;
    logic             mismatch;

    assign shamt       = operand_b[4:0];
    assign lt_signed   = $signed(operand_a) < $signed(operand_b);
    assign lt_unsigned = operand_a < operand_b;

    always_comb begin
        exp_now = '0;
        case (alu_ctrl)
            4'b0000: exp_now = operand_a + operand_b;
            4'b0001: exp_now = operand_a - operand_b;
            4'b0010: exp_now = operand_a & operand_b;
            4'b0011: exp_now = operand_a | operand_b;
            4'b0100: exp_now = operand_a ^ operand_b;
            4'b0101: exp_now = operand_a << shamt;
            4'b0110: exp_now = operand_a >> shamt;
            4'b0111: exp_now = $signed(operand_a) >>> shamt;
            4'b1000: exp_now = {{(WIDTH-1){1'b0}}, lt_signed};
            4'b1001: exp_now = {{(WIDTH-1){1'b0}}, lt_unsigned};
            default: exp_now = '0;
        endcase
    end

    // Only ops issued while RUN enter the delay line; everything else is a bubble.
    assign issue = (state == RUN) && op_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALU_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_exp[i]   <= '0;
                pipe_ctrl[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_exp[0]   <= exp_now;
            pipe_ctrl[0]  <= alu_ctrl;
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_exp[i]   <= pipe_exp[i-1];
                pipe_ctrl[i]  <= pipe_ctrl[i-1];
            end
        end
    end

    assign chk_valid = pipe_valid[ALU_LAT-1];
    assign chk_exp   = pipe_exp[ALU_LAT-1];
    assign chk_ctrl  = pipe_ctrl[ALU_LAT-1];

`ifdef ALU_CHK_ZERO_CHECK_EN
    assign mismatch = (alu_result != chk_exp) || (zero_flag != (chk_exp == '0));
`else
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
    assign mismatch = (alu_result != chk_exp);
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (op_valid && op_last) state_next = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    assign run_clear = (state == IDLE) && start;

    // Result registers stay frozen outside a run because the delay line is empty then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count   <= '0;
            fail_count   <= '0;
            err_flag     <= 1'b0;
            err_ctrl     <= '0;
            err_expected <= '0;
            err_actual   <= '0;
        end else if (run_clear) begin
            pass_count   <= '0;
            fail_count   <= '0;
            err_flag     <= 1'b0;
            err_ctrl     <= '0;
            err_expected <= '0;
            err_actual   <= '0;
        end else if (chk_valid) begin
            if (mismatch) begin
                if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
                if (!err_flag) begin
                    err_flag     <= 1'b1;
                    err_ctrl     <= chk_ctrl;
                    err_expected <= chk_exp;
                    err_actual   <= alu_result;
                end
            end else if (pass_count != 16'hFFFF) begin
                pass_count <= pass_count + 16'd1;
            end
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: plays the ALU (responses delayed LAT cycles) and scores each run
// against a sequence-level reference model.
module tb_alu_checker;
    localparam int W   = 32;
    localparam int LAT = 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;

    logic         clk = 1'b0;
    logic         rst_n, start, op_valid, op_last, zero_flag;
    logic [W-1:0] operand_a, operand_b, alu_result;
    logic [3:0]   alu_ctrl;
    logic         busy, done, err_flag;
    logic [15:0]  pass_count, fail_count;
    logic [3:0]   err_ctrl;
    logic [W-1:0] err_expected, err_actual;

    int total = 0;
    int bad   = 0;

    logic [W:0] resp_q[$];

    int         m_pass, m_fail;
    logic       m_err;
    logic [3:0] m_ctrl;
    logic [W-1:0] m_exp, m_act;

    alu_checker #(.WIDTH(W), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_last(op_last),
        .operand_a(operand_a), .operand_b(operand_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .zero_flag(zero_flag),
        .busy(busy), .done(done), .pass_count(pass_count), .fail_count(fail_count),
        .err_flag(err_flag), .err_ctrl(err_ctrl), .err_expected(err_expected),
        .err_actual(err_actual)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [3:0] ctrl);
        logic [4:0]   sh;
        logic [W-1:0] r;
        sh = b[4:0];
        case (ctrl)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: r = (a >> sh) | ((a[W-1] && sh != 5'd0) ? ~({W{1'b1}} >> sh) : '0);
            4'd8: r = (int'(a) < int'(b)) ? W'(1) : W'(0);
            4'd9: r = (a < b) ? W'(1) : W'(0);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string pre);
        check({pre, "_pass"}, pass_count, 64'(m_pass));
        check({pre, "_fail"}, fail_count, 64'(m_fail));
        check({pre, "_err_flag"}, err_flag, m_err);
        check({pre, "_err_ctrl"}, err_ctrl, m_ctrl);
        check({pre, "_err_exp"}, err_expected, m_exp);
        check({pre, "_err_act"}, err_actual, m_act);
    endtask

    task automatic check_zero(input string pre);
        check({pre, "_busy"}, busy, 0);
        check({pre, "_done"}, done, 0);
        check({pre, "_pass"}, pass_count, 0);
        check({pre, "_fail"}, fail_count, 0);
        check({pre, "_err_flag"}, err_flag, 0);
        check({pre, "_err_ctrl"}, err_ctrl, 0);
        check({pre, "_err_exp"}, err_expected, 0);
        check({pre, "_err_act"}, err_actual, 0);
    endtask

    task automatic reset_resp();
        resp_q.delete();
        for (int i = 0; i < LAT; i++) resp_q.push_back('0);
    endtask

    // One clock of stimulus; the ALU output shown now is the response queued LAT steps ago.
    task automatic step(input logic s, input logic v, input logic l, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [3:0] c, input logic [W-1:0] res,
                        input logic zf);
        logic [W:0] front;
        start = s; op_valid = v; op_last = l;
        operand_a = a; operand_b = b; alu_ctrl = c;
        front = resp_q.pop_front();
        alu_result = front[W-1:0];
        zero_flag  = front[W];
        resp_q.push_back({zf, res});
        @(negedge clk);
    endtask

    task automatic junk_step(input logic allow_start);
        step(allow_start & 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
             $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                            input logic [W-1:0] res, input logic zf);
        logic [W-1:0] e;
        logic         mis;
        e   = ref_result(a, b, c);
        mis = (res !== e);
`ifdef ALU_CHK_ZERO_CHECK_EN
        mis = mis || (zf !== (e == '0));
`endif
        if (mis) begin
            if (m_fail < 65535) m_fail++;
            if (!m_err) begin
                m_err = 1'b1; m_ctrl = c; m_exp = e; m_act = res;
            end
        end else if (m_pass < 65535) begin
            m_pass++;
        end
    endtask

    task automatic send_op(input logic s, input logic l, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [3:0] c, input logic [W-1:0] res,
                           input logic zf);
        model_op(a, b, c, res, zf);
        step(s, 1'b1, l, a, b, c, res, zf);
    endtask

    task automatic start_run();
        m_pass = 0; m_fail = 0; m_err = 1'b0; m_ctrl = '0; m_exp = '0; m_act = '0;
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic finish_run();
        int waited;
        waited = 0;
        check("drain_busy", busy, 1);
        check("drain_done", done, 0);
        while (done !== 1'b1 && waited < 20) begin
            junk_step(1'b1);
            waited++;
        end
        check("done_latency", 64'(waited), 64'(LAT));
        check("done_busy", busy, 0);
        check_model("end");
        junk_step(1'b0);
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        junk_step(1'b0);
        check_model("hold");
    endtask

    initial begin
        logic [W-1:0] a, b, e, res;
        logic [3:0]   c;
        logic         zf;
        int           n;

        rst_n = 1'b0; start = 1'b0; op_valid = 1'b0; op_last = 1'b0;
        operand_a = '0; operand_b = '0; alu_ctrl = '0; alu_result = '0; zero_flag = 1'b0;
        reset_resp();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_busy", busy, 0);

        // ADD matches, then SUB with a wrong result as the last op
        start_run();
        send_op(1'b0, 1'b0, 10, 20, OP_ADD, 30, 1'b0);
        send_op(1'b0, 1'b1, 30, 10, OP_SUB, 21, 1'b0);
        check("add_pass", pass_count, 1);
        check("add_fail", fail_count, 0);
        check("add_err", err_flag, 0);
        finish_run();
        check("sub_fail", fail_count, 1);
        check("sub_err", err_flag, 1);
        check("sub_ctrl", err_ctrl, 4'b0001);
        check("sub_exp", err_expected, 20);
        check("sub_act", err_actual, 21);

        // AND then SLL, both correct; start clears the previous run's error
        start_run();
        send_op(1'b0, 1'b0, 32'hF0F0, 32'h0FF0, OP_AND, 32'h00F0, 1'b0);
        send_op(1'b0, 1'b1, 1, 5, OP_SLL, 32'h20, 1'b0);
        finish_run();
        check("andsll_pass", pass_count, 2);
        check("andsll_fail", fail_count, 0);
        check("andsll_err", err_flag, 0);

        // zero result reported with a wrong zero_flag
        start_run();
        send_op(1'b0, 1'b1, 5, 5, OP_SUB, 0, 1'b0);
        finish_run();
`ifdef ALU_CHK_ZERO_CHECK_EN
        check("zf_fail", fail_count, 1);
        check("zf_pass", pass_count, 0);
`else
        check("zf_pass", pass_count, 1);
        check("zf_fail", fail_count, 0);
`endif

        // two mismatches keep the first capture, then reset lands mid-run
        start_run();
        send_op(1'b0, 1'b0, 1, 2, OP_ADD, 4, 1'b0);
        send_op(1'b0, 1'b0, 3, 5, OP_XOR, 0, 1'b1);
        send_op(1'b1, 1'b0, 7, 7, OP_AND, 7, 1'b0);
        check("two_fail", fail_count, 2);
        check("two_pass", pass_count, 0);
        check("two_ctrl", err_ctrl, 4'b0000);
        check("two_exp", err_expected, 3);
        check("two_act", err_actual, 4);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        reset_resp();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            junk_step(1'b0);
            check("postrst_done", done, 0);
            check("postrst_busy", busy, 0);
        end
        check_zero("postrst");

        // randomized runs with bubbles, stray start/op_last and corrupted results
        for (int r = 0; r < 8; r++) begin
            start_run();
            n = $urandom_range(3, 12);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), $urandom,
                         $urandom, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
                a = $urandom;
                b = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 40));
                c = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 4) == 0) begin
                    b = a; c = OP_SUB;
                end
                e   = ref_result(a, b, c);
                res = ($urandom_range(0, 3) == 0) ? (e ^ (W'(1) << $urandom_range(0, W-1))) : e;
                zf  = (res == '0);
                if ($urandom_range(0, 5) == 0) zf = ~zf;
                send_op(1'($urandom_range(0, 1)), (k == n - 1), a, b, c, res, zf);
            end
            finish_run();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
